// File: rtl/imem_loader_if.sv
// Byte-stream, control and instruction-memory write signals of the program loader.
// The master drives the stream and controls; the slave is the loader itself.
interface imem_loader_if #(
  parameter int unsigned addWidth  = 6,
  parameter int unsigned dataWidth = 32
);
  logic                 start;
  logic [addWidth:0]    num_words;
  logic                 abort;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 mem_we;
  logic [addWidth-1:0]  mem_addr;
  logic [dataWidth-1:0] mem_wdata;
  logic [addWidth:0]    word_count;
  logic                 done;
  logic                 cpu_hold;

  modport master (
    output start, num_words, abort, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, word_count, done, cpu_hold
  );

  modport slave (
    input  start, num_words, abort, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, word_count, done, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Synthesizable program loader: assembles big-endian words from a byte stream and
// writes them to instruction memory from address 0, holding the CPU in reset meanwhile.
module imem_loader #(
  parameter int unsigned addWidth  = 6,
  parameter int unsigned dataWidth = 32
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);

  localparam int unsigned Bpw  = dataWidth / 8;
  localparam int unsigned IdxW = $clog2(Bpw + 1);
  localparam logic [addWidth:0] Cap = {1'b1, {addWidth{1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_t;

  state_t               state_q;
  logic [addWidth:0]    tgt_q;
  logic [IdxW-1:0]      idx_q;
  logic [dataWidth-1:0] asm_q;
  logic                 in_ready_q;
  logic                 mem_we_q;
  logic [addWidth-1:0]  mem_addr_q;
  logic [dataWidth-1:0] mem_wdata_q;
  logic [addWidth:0]    word_count_q;
  logic                 done_q;
  logic                 cpu_hold_q;

  logic [addWidth:0]    tgt_new;
  logic [addWidth:0]    wc_inc;
  logic [dataWidth-1:0] asm_next;
  logic                 last_byte;

  always_comb begin
    tgt_new   = (bus.num_words > Cap) ? Cap : bus.num_words;
    wc_inc    = word_count_q + 1'b1;
    asm_next  = (asm_q << 8) | dataWidth'(bus.in_data);
    last_byte = (idx_q == IdxW'(Bpw - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      tgt_q        <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            tgt_q        <= tgt_new;
            word_count_q <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            mem_addr_q   <= '0;
            if (tgt_new == '0) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= StLoad;
              in_ready_q <= 1'b1;
              done_q     <= 1'b0;
              cpu_hold_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (bus.abort) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            idx_q      <= '0;
            asm_q      <= '0;
          end else if (bus.in_valid && in_ready_q) begin
            if (last_byte) begin
              // The write strobe is registered so it appears the cycle after the last byte.
              state_q     <= StWrite;
              in_ready_q  <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= asm_next;
            end else begin
              asm_q <= asm_next;
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StWrite: begin
          mem_we_q     <= 1'b0;
          word_count_q <= wc_inc;
          mem_addr_q   <= mem_addr_q + 1'b1;
          idx_q        <= '0;
          asm_q        <= '0;
          if (bus.abort) begin
            state_q <= StIdle;
          end else if (wc_inc == tgt_q) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q    <= StLoad;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.word_count = word_count_q;
  assign bus.done       = done_q;
  assign bus.cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams and checks the logged memory writes.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  imem_loader_if #(.addWidth(6), .dataWidth(32)) bus ();

  imem_loader #(.addWidth(6), .dataWidth(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_start(input logic [6:0] n);
    bus.start     = 1'b1;
    bus.num_words = n;
    tick();
    bus.start = 1'b0;
  endtask

  // Presents bytes in order; a byte advances only when accepted (valid && ready).
  task automatic feed(input string tag, input logic [7:0] b[$], input bit toggle,
                      input int maxcyc);
    int  i = 0;
    int  c = 0;
    bit  ph = 1'b1;
    bit  acc;
    while (i < b.size() && c < maxcyc) begin
      bus.in_valid = toggle ? ph : 1'b1;
      bus.in_data  = b[i];
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) i++;
      ph = !ph;
      c++;
    end
    bus.in_valid = 1'b0;
    chk({tag, " all bytes accepted"}, 32'(i), 32'(b.size()));
  endtask

  task automatic wait_done(input string tag, input int lim);
    int c = 0;
    while (bus.done !== 1'b1 && c < lim) begin
      tick();
      c++;
    end
    chk({tag, " done"}, 32'(bus.done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, " word_count"}, 32'(bus.word_count), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
    chk({tag, " cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] big[$];
    int bad;

    bus.start = 1'b0;
    bus.num_words = '0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Two words, in_valid held high.
    s = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
    clear_log();
    do_start(7'd2);
    chk("load in_ready", 32'(bus.in_ready), 32'd1);
    feed("t1", s, 1'b0, 100);
    wait_done("t1", 20);
    chk("t1 writes", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t1 addr0", 32'(wr_addr[0]), 32'd0);
      chk("t1 data0", wr_data[0], 32'h8C010004);
      chk("t1 addr1", 32'(wr_addr[1]), 32'd1);
      chk("t1 data1", wr_data[1], 32'hAC020008);
      chk("t1 gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
    end
    chk("t1 cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("t1 word_count", 32'(bus.word_count), 32'd2);
    chk("t1 in_ready", 32'(bus.in_ready), 32'd0);

    // Backpressure: in_valid toggles every cycle; restart from DONE.
    clear_log();
    do_start(7'd2);
    chk("restart done", 32'(bus.done), 32'd0);
    chk("restart cpu_hold", 32'(bus.cpu_hold), 32'd1);
    feed("t2", s, 1'b1, 100);
    wait_done("t2", 20);
    chk("t2 writes", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t2 data0", wr_data[0], 32'h8C010004);
      chk("t2 addr1", 32'(wr_addr[1]), 32'd1);
      chk("t2 data1", wr_data[1], 32'hAC020008);
      chk("t2 gap>=8", 32'(wr_cyc[1] - wr_cyc[0] >= 8), 32'd1);
    end

    // Zero words straight to DONE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    clear_log();
    chk("t3 pre done", 32'(bus.done), 32'd0);
    do_start(7'd0);
    chk("t3 done", 32'(bus.done), 32'd1);
    chk("t3 cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("t3 word_count", 32'(bus.word_count), 32'd0);
    repeat (3) tick();
    chk("t3 writes", 32'(wr_addr.size()), 32'd0);

    // Oversized request clamps to the 64-word capacity.
    big.delete();
    for (int k = 0; k < 256; k++) big.push_back(8'(k));
    clear_log();
    do_start(7'd100);
    feed("t4", big, 1'b0, 2000);
    wait_done("t4", 20);
    chk("t4 writes", 32'(wr_addr.size()), 32'd64);
    bad = 0;
    for (int w = 0; w < wr_addr.size(); w++) begin
      if (wr_addr[w] !== 6'(w)) bad++;
      if (wr_data[w] !== {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)}) bad++;
    end
    chk("t4 addr/data errors", 32'(bad), 32'd0);
    chk("t4 word_count", 32'(bus.word_count), 32'd64);

    // Abort after one word plus two bytes.
    s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clear_log();
    do_start(7'd2);
    feed("t5", s, 1'b0, 100);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5 in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5 word_count", 32'(bus.word_count), 32'd1);
    chk("t5 done", 32'(bus.done), 32'd0);
    chk("t5 cpu_hold", 32'(bus.cpu_hold), 32'd1);
    repeat (4) tick();
    chk("t5 writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) chk("t5 data0", wr_data[0], 32'h11223344);

    s = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_log();
    do_start(7'd1);
    feed("t5b", s, 1'b0, 100);
    wait_done("t5b", 20);
    chk("t5b writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t5b addr", 32'(wr_addr[0]), 32'd0);
      chk("t5b data", wr_data[0], 32'hDEADBEEF);
    end
    chk("t5b word_count", 32'(bus.word_count), 32'd1);

    // start during LOAD is ignored, then asynchronous reset mid-load.
    s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_start(7'd3);
    feed("t6", s, 1'b0, 100);
    bus.num_words = 7'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t6 wc after start", 32'(bus.word_count), 32'd1);
    chk("t6 in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6 done", 32'(bus.done), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    tick();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
